solver_dispatcher: RTL and testbench

Work scheduler for the fractal solver array. It walks the complex-plane grid from (min_x, min_y) to (max_x, max_y) in row-major order. Each grid point and its linear pixel address are handed to the next free solver under round-robin arbitration. Ownership of every solver is tracked until it reports completion, and frame-level done is raised once all points are issued and all solvers are drained. It sits between the frame-configuration registers and the per-solver iteration engines inside multi_solver.

---
 rtl/solver_dispatcher.sv | 167 ++++++++++++++++
 tb/tb_solver_dispatcher.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/solver_dispatcher.sv
// Round-robin work scheduler: walks the frame grid row-major and hands each point to a free solver.
// Optional frame busy-cycle counter (frame_cycles) is built when DISPATCH_STATS_EN is defined.
module solver_dispatcher #(
   parameter int NUM_SOLVERS = 11,
   parameter int WIDTH       = 27,
   parameter int ADDR_WIDTH  = 19
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic signed [WIDTH-1:0] min_x,
   input  logic signed [WIDTH-1:0] min_y,
   input  logic signed [WIDTH-1:0] max_x,
   input  logic signed [WIDTH-1:0] max_y,
   input  logic signed [WIDTH-1:0] dx,
   input  logic signed [WIDTH-1:0] dy,
   input  logic [NUM_SOLVERS-1:0]  solver_ready,
   input  logic [NUM_SOLVERS-1:0]  solver_done,
   output logic [NUM_SOLVERS-1:0]  assign_valid,
   output logic signed [WIDTH-1:0] assign_x,
   output logic signed [WIDTH-1:0] assign_y,
   output logic [ADDR_WIDTH-1:0]   assign_addr,
   output logic                    busy,
   output logic                    done
`ifdef DISPATCH_STATS_EN
   ,
   output logic [31:0]             frame_cycles
`endif
);

   localparam int PTR_W = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1;

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

   state_t                  state, state_nxt;
   logic signed [WIDTH-1:0] min_x_q, min_y_q, max_x_q, max_y_q, dx_q, dy_q;
   logic signed [WIDTH-1:0] x_p0, y_p0;
   logic [ADDR_WIDTH-1:0]   addr_p0;
   logic [NUM_SOLVERS-1:0]  claimed, claimed_nxt, eligible, grant;
   logic [PTR_W-1:0]        rr_ptr, rr_ptr_nxt;
   logic                    load, step, empty_frame, row_end, last_point;
   logic signed [WIDTH:0]   nx, ny;

   // First eligible solver at or after ptr, wrapping around the solver ring.
   function automatic logic [NUM_SOLVERS-1:0] rr_pick(input logic [NUM_SOLVERS-1:0] elig,
                                                      input logic [PTR_W-1:0] ptr);
      logic [NUM_SOLVERS-1:0] g;
      logic                   found;
      int                     idx;
      g     = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_SOLVERS; i++) begin
         idx = int'(ptr) + i;
         if (idx >= NUM_SOLVERS) idx = idx - NUM_SOLVERS;
         if (!found && elig[idx]) begin
            g[idx] = 1'b1;
            found  = 1'b1;
         end
      end
      return g;
   endfunction

   function automatic logic [PTR_W-1:0] ptr_after(input logic [NUM_SOLVERS-1:0] g);
      logic [PTR_W-1:0] p;
      p = '0;
      for (int i = 0; i < NUM_SOLVERS; i++)
         if (g[i]) p = (i == NUM_SOLVERS - 1) ? '0 : PTR_W'(i + 1);
      return p;
   endfunction

   // One guard bit keeps the step past max from wrapping negative.
   assign nx          = (WIDTH+1)'(x_p0) + (WIDTH+1)'(dx_q);
   assign ny          = (WIDTH+1)'(y_p0) + (WIDTH+1)'(dy_q);
   assign row_end     = nx > (WIDTH+1)'(max_x_q);
   assign last_point  = row_end && (ny > (WIDTH+1)'(max_y_q));
   assign empty_frame = (min_x > max_x) || (min_y > max_y);
   assign eligible    = solver_ready & ~claimed;

   always_comb begin
      state_nxt   = state;
      grant       = '0;
      load        = 1'b0;
      step        = 1'b0;
      claimed_nxt = claimed & ~solver_done;
      rr_ptr_nxt  = rr_ptr;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               load        = 1'b1;
               claimed_nxt = '0;
               state_nxt   = empty_frame ? DRAIN : SCAN;
            end
         end
         SCAN: begin
            grant = rr_pick(eligible, rr_ptr);
            if (grant != '0) begin
               step        = 1'b1;
               claimed_nxt = claimed_nxt | grant;
               rr_ptr_nxt  = ptr_after(grant);
               if (last_point) state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (claimed == '0) state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Control and issued-point registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         claimed      <= '0;
         rr_ptr       <= '0;
         assign_valid <= '0;
         assign_x     <= '0;
         assign_y     <= '0;
         assign_addr  <= '0;
      end else begin
         state        <= state_nxt;
         claimed      <= claimed_nxt;
         rr_ptr       <= rr_ptr_nxt;
         assign_valid <= grant;
         if (step) begin
            assign_x    <= x_p0;
            assign_y    <= y_p0;
            assign_addr <= addr_p0;
         end
      end
   end

   // Frame configuration and grid walker
   always_ff @(posedge clock) begin
      if (load) begin
         min_x_q <= min_x;
         min_y_q <= min_y;
         max_x_q <= max_x;
         max_y_q <= max_y;
         dx_q    <= dx;
         dy_q    <= dy;
         x_p0    <= min_x;
         y_p0    <= min_y;
         addr_p0 <= '0;
      end else if (step) begin
         addr_p0 <= addr_p0 + ADDR_WIDTH'(1);
         if (row_end) begin
            x_p0 <= min_x_q;
            y_p0 <= ny[WIDTH-1:0];
         end else begin
            x_p0 <= nx[WIDTH-1:0];
         end
      end
   end

   assign busy = (state == SCAN) || (state == DRAIN);
   assign done = (state == DONE);

`ifdef DISPATCH_STATS_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset)      frame_cycles <= '0;
      else if (load)  frame_cycles <= '0;
      else if (busy)  frame_cycles <= frame_cycles + 32'd1;
   end
`endif

endmodule

// File: tb/tb_solver_dispatcher.sv
// Directed self-checking bench for solver_dispatcher with a fixed-latency solver responder.
module tb_solver_dispatcher;
   localparam int NS   = 11;
   localparam int W    = 27;
   localparam int AW   = 19;
   localparam int SEEN = 8192;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic                reset, start;
   logic signed [W-1:0] min_x, min_y, max_x, max_y, dx, dy;
   logic [NS-1:0]       solver_ready;
   logic [NS-1:0]       solver_done = '0;
   logic [NS-1:0]       assign_valid;
   logic signed [W-1:0] assign_x, assign_y;
   logic [AW-1:0]       assign_addr;
   logic                busy, done;
`ifdef DISPATCH_STATS_EN
   logic [31:0]         frame_cycles;
`endif

   int     checks = 0;
   int     failures = 0;
   longint cfg_min_x, cfg_min_y, cfg_dx, cfg_dy;
   int     cols = 1;
   int     resp_delay = 1;
   logic   new_frame = 1'b0;

   int            n_frame = 0, seq_err = 0, coord_err = 0, owned_err = 0, onehot_err = 0, dup = 0;
   logic [NS-1:0] owned = '0;
   int            cnt [NS];
   bit            seen [SEEN];
   int            rr_q [$];
   longint        last_x = 0, last_y = 0;
   int            last_addr = 0;

   solver_dispatcher #(.NUM_SOLVERS(NS), .WIDTH(W), .ADDR_WIDTH(AW)) dut (
      .clock(clock), .reset(reset), .start(start),
      .min_x(min_x), .min_y(min_y), .max_x(max_x), .max_y(max_y), .dx(dx), .dy(dy),
      .solver_ready(solver_ready), .solver_done(solver_done),
      .assign_valid(assign_valid), .assign_x(assign_x), .assign_y(assign_y),
      .assign_addr(assign_addr), .busy(busy), .done(done)
`ifdef DISPATCH_STATS_EN
      , .frame_cycles(frame_cycles)
`endif
   );

   // Scoreboard and solver responder: each solver pulses done resp_delay cycles after its grant.
   always @(negedge clock) begin
      if (reset) begin
         owned       = '0;
         solver_done = '0;
         for (int i = 0; i < NS; i++) cnt[i] = 0;
      end else begin
         if (new_frame) begin
            n_frame = 0; seq_err = 0; coord_err = 0; owned_err = 0; onehot_err = 0; dup = 0;
            rr_q.delete();
            for (int a = 0; a < SEEN; a++) seen[a] = 1'b0;
         end
         if (assign_valid != '0) begin
            int     a;
            longint ex, ey;
            a  = int'(assign_addr);
            ex = cfg_min_x + longint'(a % cols) * cfg_dx;
            ey = cfg_min_y + longint'(a / cols) * cfg_dy;
            if (!$onehot(assign_valid)) onehot_err++;
            if ((assign_valid & owned) != '0) owned_err++;
            if (a != n_frame) seq_err++;
            if (a < SEEN) begin
               if (seen[a]) dup++;
               seen[a] = 1'b1;
            end
            if (longint'(assign_x) != ex || longint'(assign_y) != ey) coord_err++;
            for (int i = 0; i < NS; i++) if (assign_valid[i]) rr_q.push_back(i);
            last_x    = longint'(assign_x);
            last_y    = longint'(assign_y);
            last_addr = a;
            n_frame++;
         end
         owned = (owned & ~solver_done) | assign_valid;
         for (int i = 0; i < NS; i++) begin
            solver_done[i] = 1'b0;
            if (assign_valid[i]) cnt[i] = resp_delay;
            else if (cnt[i] != 0) begin
               cnt[i] = cnt[i] - 1;
               if (cnt[i] == 0) solver_done[i] = 1'b1;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   task automatic set_cfg(input longint mnx, input longint mny, input longint mxx, input longint mxy,
                          input longint ddx, input longint ddy, input int c);
      min_x = W'(mnx); min_y = W'(mny); max_x = W'(mxx); max_y = W'(mxy); dx = W'(ddx); dy = W'(ddy);
      cfg_min_x = mnx; cfg_min_y = mny; cfg_dx = ddx; cfg_dy = ddy; cols = c;
   endtask

   task automatic do_start(input logic accepted);
      start     = 1'b1;
      new_frame = accepted;
      tick();
      start     = 1'b0;
      new_frame = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string tag);
      int k;
      k = 0;
      while (done !== 1'b1 && k < budget) begin
         tick();
         k++;
      end
      chk(tag, done, 1);
   endtask

   initial begin
      int n0, nb, k, nseen, busy_cnt;
      reset = 1'b1; start = 1'b0; solver_ready = '0;
      set_cfg(0, 0, 0, 0, 0, 0, 1);
      repeat (3) tick();
      reset = 1'b0;
      tick();

      // reset state
      chk("rst_valid", assign_valid, 0);
      chk("rst_x", assign_x, 0);
      chk("rst_y", assign_y, 0);
      chk("rst_addr", assign_addr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
`ifdef DISPATCH_STATS_EN
      chk("rst_cycles", frame_cycles, 0);
`endif

      // round-robin between solvers 3 and 7 on a 4x2 grid, plus start latency
      set_cfg(0, 0, 3, 1, 1, 1, 4);
      solver_ready = 11'h088;
      resp_delay   = 5;
      do_start(1'b1);
      chk("lat_busy_e0", busy, 1);
      chk("lat_valid_e0", assign_valid, 0);
      tick();
      chk("lat_valid_e1", assign_valid, 11'h008);
      chk("lat_addr_e1", assign_addr, 0);
      wait_done(500, "rr_done");
      chk("rr_count", rr_q.size(), 8);
      for (int i = 0; i < 8 && i < rr_q.size(); i++)
         chk($sformatf("rr_seq%0d", i), rr_q[i], (i % 2 == 0) ? 3 : 7);
      chk("rr_owned", owned_err, 0);
      chk("rr_coord", coord_err, 0);

      // empty frame
      set_cfg((1 << 20) + 1, 0, 1 << 20, 1 << 20, 31775, 31775, 1);
      do_start(1'b1);
      chk("empty_busy_e0", busy, 1);
      chk("empty_done_e0", done, 0);
      tick();
      chk("empty_done", done, 1);
      chk("empty_busy", busy, 0);
      chk("empty_assigns", n_frame, 0);

      // full 100x67 frame, all solvers, 20-cycle solve time
      set_cfg(-2097152, -1048576, 1048576, 1048576, 31775, 31775, 100);
      solver_ready = '1;
      resp_delay   = 20;
      do_start(1'b1);
      wait_done(30000, "full_done");
      nseen = 0;
      for (int a = 0; a < 6700; a++) if (seen[a]) nseen++;
      chk("full_count", n_frame, 6700);
      chk("full_seen", nseen, 6700);
      chk("full_dup", dup, 0);
      chk("full_seq", seq_err, 0);
      chk("full_coord", coord_err, 0);
      chk("full_onehot", onehot_err, 0);
      chk("full_owned", owned_err, 0);
      chk("full_last_x", last_x, 1048573);
      chk("full_last_y", last_y, 1048574);
      chk("full_last_addr", last_addr, 6699);
      chk("full_busy", busy, 0);

      // backpressure: 50 cycles with nobody ready mid-frame
      set_cfg(0, 0, 9, 9, 1, 1, 10);
      resp_delay = 3;
      do_start(1'b1);
      k = 0;
      while (n_frame < 20 && k < 200) begin tick(); k++; end
      chk("bp_reach", n_frame >= 20, 1);
      solver_ready = '0;
      tick();
      n0 = n_frame;
      repeat (50) tick();
      chk("bp_no_assign", n_frame, n0);
      chk("bp_addr_hold", assign_addr, n0 - 1);
      chk("bp_busy", busy, 1);
      solver_ready = '1;
      k = 0;
      while (n_frame == n0 && k < 20) begin tick(); k++; end
      chk("bp_resume_addr", last_addr, n0);
      chk("bp_resume_x", last_x, n0 % 10);
      chk("bp_resume_y", last_y, n0 / 10);
      wait_done(2000, "bp_done");
      chk("bp_count", n_frame, 100);
      chk("bp_seq", seq_err, 0);

      // start during SCAN is ignored, then asynchronous reset mid-frame
      set_cfg(0, 0, 9, 9, 1, 1, 10);
      do_start(1'b1);
      k = 0;
      while (n_frame < 10 && k < 200) begin tick(); k++; end
      nb = n_frame;
      min_x = W'(100);
      do_start(1'b0);
      min_x = W'(0);
      repeat (5) tick();
      chk("scan_start_busy", busy, 1);
      chk("scan_start_seq", seq_err, 0);
      chk("scan_start_coord", coord_err, 0);
      chk("scan_start_progress", n_frame > nb, 1);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_valid", assign_valid, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_addr", assign_addr, 0);
      chk("arst_x", assign_x, 0);
      chk("arst_y", assign_y, 0);
      tick();
      tick();
      reset = 1'b0;
      tick();
      chk("post_rst_busy", busy, 0);
      chk("post_rst_done", done, 0);
      do_start(1'b1);
      tick();
      chk("restart_valid", assign_valid, 11'h001);
      chk("restart_addr", assign_addr, 0);
      chk("restart_x", assign_x, 0);
      wait_done(2000, "restart_done");
      chk("restart_count", n_frame, 100);
      chk("restart_seq", seq_err, 0);

`ifdef DISPATCH_STATS_EN
      // busy-cycle counter on a single-solver 2x2 frame
      set_cfg(0, 0, 1, 1, 1, 1, 2);
      solver_ready = 11'h001;
      resp_delay   = 5;
      do_start(1'b1);
      busy_cnt = 0;
      k = 0;
      while (done !== 1'b1 && k < 500) begin
         if (busy === 1'b1) busy_cnt++;
         tick();
         k++;
      end
      chk("stats_done", done, 1);
      chk("stats_cycles", frame_cycles, busy_cnt);
      repeat (5) tick();
      chk("stats_frozen", frame_cycles, busy_cnt);
      chk("stats_count", n_frame, 4);
`else
      busy_cnt = 0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
